// File: rtl/dac_buf_pkg.sv
// Shared types and register map for the DAC ping-pong playback buffer.
package dac_buf_pkg;

  typedef enum logic {IDLE, PLAY} state_e;

  localparam logic [15:0] CTRL_ADDR  = 16'h4000;
  localparam logic [15:0] LEN_ADDR   = 16'h4001;
  localparam logic [15:0] LOOPS_ADDR = 16'h4002;
  localparam logic [3:0]  SMP_REGION = 4'h0;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_RUN_BIT    = 1;

endpackage

// File: rtl/dac_dual_buffer_ram.sv
// Two-bank sample store: bus port A (write + registered read), playback port B (registered read).
module dp_sample_ram #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk) begin
    if (a_re) a_rdata <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    if (b_re) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/dac_dual_buffer.sv
// Ping-pong waveform playback: MCU fills the idle bank, commits, and the active bank
// is streamed to the DAC on each dac_clk rising edge; swaps happen only at wrap.
module dac_dual_buffer
  import dac_buf_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 16,
  parameter int                     SAMPLE_WIDTH = 12,
  parameter int                     BUF_SIZE     = 1024,
  parameter logic [SAMPLE_WIDTH-1:0] IDLE_CODE   = 12'h800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    addr_en,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    dac_clk,
  output logic [SAMPLE_WIDTH-1:0] dac_data,
  output logic                    dac_valid
);

  localparam int AW = $clog2(BUF_SIZE);

  state_e            state;
  logic [15:0]       addr_q;
  logic              play_bank, run, pending, bank_valid;
  logic [AW-1:0]     play_len, shadow_len, rd_ptr;
  logic [15:0]       loop_cnt;
  logic              dac_clk_prev;
  logic [1:0]        vld_pipe;
  logic              rd_sel_ram;
  logic [DATA_WIDTH-1:0] rd_hold, reg_rdata;
  logic [SAMPLE_WIDTH-1:0] ram_a_rdata, ram_b_rdata;

  logic bus_wr, bus_rd, is_smp, ctrl_wr, len_wr, commit;
  logic tick, play_tick, wrap, do_swap;

  assign bus_wr  = en & rd_en;
  assign bus_rd  = en & wr_en;
  assign is_smp  = (addr_q[15:12] == SMP_REGION);
  assign ctrl_wr = bus_wr && (addr_q == CTRL_ADDR);
  assign len_wr  = bus_wr && (addr_q == LEN_ADDR);
  assign commit  = ctrl_wr & rd_data[CTRL_COMMIT_BIT];

  assign tick      = dac_clk & ~dac_clk_prev;
  assign play_tick = (state == PLAY) & run & tick;
  assign wrap      = (rd_ptr == play_len);

  // A pending swap is honoured on any IDLE cycle, so a commit that lands on the
  // exit cycle from PLAY is never stranded.
  always_comb begin
    do_swap = 1'b0;
    if (state == IDLE || !run) do_swap = pending | commit;
    else                       do_swap = play_tick & wrap & pending;
  end

  always_comb begin
    reg_rdata = '1;
    if (addr_q == CTRL_ADDR)       reg_rdata = DATA_WIDTH'({bank_valid, run, pending});
    else if (addr_q == LEN_ADDR)   reg_rdata = DATA_WIDTH'(shadow_len);
    else if (addr_q == LOOPS_ADDR) reg_rdata = DATA_WIDTH'(loop_cnt);
  end

  dp_sample_ram #(.AW(AW + 1), .DW(SAMPLE_WIDTH)) u_ram (
    .clk     (clk),
    .a_we    (bus_wr & is_smp & ~pending),
    .a_re    (bus_rd & is_smp),
    .a_addr  ({~play_bank, addr_q[AW-1:0]}),
    .a_wdata (rd_data[SAMPLE_WIDTH-1:0]),
    .a_rdata (ram_a_rdata),
    .b_re    (play_tick),
    .b_addr  ({play_bank, rd_ptr}),
    .b_rdata (ram_b_rdata)
  );

  // Register reads and sample reads both appear the clock after the read strobe.
  assign wr_data   = rd_sel_ram ? DATA_WIDTH'(ram_a_rdata) : rd_hold;
  assign dac_valid = vld_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_sel_ram <= 1'b0;
      rd_hold    <= '1;
    end else begin
      if (en && addr_en) addr_q <= rd_data[15:0];
      if (bus_rd) begin
        rd_sel_ram <= is_smp;
        if (!is_smp) rd_hold <= reg_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      play_bank    <= 1'b0;
      run          <= 1'b0;
      pending      <= 1'b0;
      bank_valid   <= 1'b0;
      play_len     <= AW'(BUF_SIZE - 1);
      shadow_len   <= AW'(BUF_SIZE - 1);
      loop_cnt     <= '0;
      rd_ptr       <= '0;
      dac_clk_prev <= 1'b0;
      vld_pipe     <= '0;
      dac_data     <= IDLE_CODE;
    end else begin
      dac_clk_prev <= dac_clk;
      vld_pipe     <= {vld_pipe[0], play_tick};
      if (vld_pipe[0]) dac_data <= ram_b_rdata;
      if (ctrl_wr)     run <= rd_data[CTRL_RUN_BIT];
      if (len_wr)      shadow_len <= rd_data[AW-1:0];

      case (state)
        IDLE: begin
          if (run && bank_valid) begin
            state  <= PLAY;
            rd_ptr <= '0;
          end
        end
        PLAY: begin
          if (!run) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            vld_pipe <= '0;
            dac_data <= IDLE_CODE;
          end else begin
            if (commit && !pending) pending <= 1'b1;
            if (play_tick) begin
              if (wrap) begin
                rd_ptr <= '0;
                if (loop_cnt != 16'hFFFF) loop_cnt <= loop_cnt + 16'd1;
              end else begin
                rd_ptr <= rd_ptr + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed last so the swap's loop_cnt clear and pending clear win.
      if (do_swap) begin
        play_bank  <= ~play_bank;
        play_len   <= shadow_len;
        bank_valid <= 1'b1;
        loop_cnt   <= '0;
        pending    <= 1'b0;
      end
    end
  end

endmodule
